hood_mode_ctrl: RTL

Parametrised successor to the range-hood mode FSM. Supports NUM_SPEEDS suction levels, live speed change while running, and a cancellable delayed shutdown from top speed. It also provides a timed self-clean cycle with a seconds countdown output for the display driver. Sits between the button debouncers and the motor/display blocks.

---
 rtl/hood_mode_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: range-hood mode controller.
// Handles STANDBY / MENU / RUN / DRAIN / CLEAN with NUM_SPEEDS suction levels, a cancellable
// delayed shutdown from top speed, and a timed self-clean cycle with a seconds countdown.
// Optional build macro HOOD_MENU_TIMEOUT_EN: MENU returns to STANDBY after MENU_TIMEOUT_S
// idle seconds. Without it MENU waits indefinitely and no menu counter exists.

module hood_mode_ctrl #(
   parameter int unsigned NUM_SPEEDS      = 3,
   parameter int unsigned CLK_HZ          = 100000000,
   parameter int unsigned TOP_OFF_DELAY_S = 60,
   parameter int unsigned CLEAN_TIME_S    = 180,
   parameter int unsigned MENU_TIMEOUT_S  = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  menu_btn,
   input  logic [NUM_SPEEDS-1:0] speed_btn,
   input  logic                  clean_btn,
   output logic [2:0]            mode,
   output logic [2:0]            speed_level,
   output logic                  countdown,
   output logic [15:0]           remaining_s,
   output logic                  clean_done
);

   localparam int unsigned          PRESC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRESC_W-1:0]   PRESC_MAX  = PRESC_W'(CLK_HZ - 1);
   localparam logic [2:0]           TOP_LEVEL  = 3'(NUM_SPEEDS);
   localparam logic [15:0]          DRAIN_SECS = 16'(TOP_OFF_DELAY_S);
   localparam logic [15:0]          CLEAN_SECS = 16'(CLEAN_TIME_S);

   // Parameter range checks, evaluated at elaboration only.
   if (NUM_SPEEDS < 2 || NUM_SPEEDS > 7) begin : g_chk_speeds
      $error("hood_mode_ctrl: NUM_SPEEDS must be 2..7");
   end
   if (CLK_HZ < 1) begin : g_chk_clk
      $error("hood_mode_ctrl: CLK_HZ must be at least 1");
   end
   if (TOP_OFF_DELAY_S < 1 || TOP_OFF_DELAY_S > 65535) begin : g_chk_drain
      $error("hood_mode_ctrl: TOP_OFF_DELAY_S must be 1..65535");
   end
   if (CLEAN_TIME_S < 1 || CLEAN_TIME_S > 65535) begin : g_chk_clean
      $error("hood_mode_ctrl: CLEAN_TIME_S must be 1..65535");
   end
   if (MENU_TIMEOUT_S < 1 || MENU_TIMEOUT_S > 65535) begin : g_chk_menu
      $error("hood_mode_ctrl: MENU_TIMEOUT_S must be 1..65535");
   end

   typedef enum logic [2:0] {
      StStandby = 3'd0,
      StMenu    = 3'd1,
      StRun     = 3'd2,
      StDrain   = 3'd3,
      StClean   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           speed_q, speed_d;
   logic [15:0]          rem_q, rem_d;
   logic                 cd_q, cd_d;
   logic                 done_q, done_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic                 presc_run;
   logic                 tick;
   logic [2:0]           speed_hits;
   logic [2:0]           speed_sel;
   logic                 speed_valid;

`ifdef HOOD_MENU_TIMEOUT_EN
   localparam logic [15:0] MENU_LAST = 16'(MENU_TIMEOUT_S - 1);
   logic [15:0]          menu_sec_q, menu_sec_d;
`endif

   // Decode speed buttons: valid only with exactly one bit set.
   always_comb begin
      speed_hits = 3'd0;
      speed_sel  = 3'd0;
      for (int i = 0; i < NUM_SPEEDS; i++) begin
         if (speed_btn[i]) begin
            speed_hits = speed_hits + 3'd1;
            speed_sel  = 3'(i + 1);
         end
      end
      speed_valid = (speed_hits == 3'd1);
   end

   // Second tick: prescaler wraps once per CLK_HZ cycles in counting states.
   always_comb begin
      presc_run = (state_q == StDrain) || (state_q == StClean);
`ifdef HOOD_MENU_TIMEOUT_EN
      presc_run = presc_run || (state_q == StMenu);
`endif
      tick = presc_run && (presc_q == PRESC_MAX);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      speed_d = speed_q;
      rem_d   = rem_q;
      cd_d    = cd_q;
      done_d  = 1'b0;
`ifdef HOOD_MENU_TIMEOUT_EN
      menu_sec_d = (state_q == StMenu) ? menu_sec_q : 16'd0;
`endif

      unique case (state_q)
         StStandby: begin
            if (menu_btn) begin
               state_d = StMenu;
            end
         end

         StMenu: begin
            if (speed_valid) begin
               state_d = StRun;
               speed_d = speed_sel;
            end else if (clean_btn) begin
               state_d = StClean;
               speed_d = 3'd0;
               rem_d   = CLEAN_SECS;
               cd_d    = 1'b1;
            end else if (menu_btn) begin
               state_d = StStandby;
            end
`ifdef HOOD_MENU_TIMEOUT_EN
            else if (tick) begin
               if (menu_sec_q >= MENU_LAST) begin
                  state_d = StStandby;
               end else begin
                  menu_sec_d = menu_sec_q + 16'd1;
               end
            end
`endif
         end

         StRun: begin
            // menu_btn has priority over a simultaneous speed change.
            if (menu_btn) begin
               if (speed_q == TOP_LEVEL) begin
                  state_d = StDrain;
                  rem_d   = DRAIN_SECS;
                  cd_d    = 1'b1;
               end else begin
                  state_d = StStandby;
                  speed_d = 3'd0;
               end
            end else if (speed_valid) begin
               speed_d = speed_sel;
            end
         end

         StDrain: begin
            // Cancel beats a coinciding tick.
            if (menu_btn) begin
               state_d = StRun;
               rem_d   = 16'd0;
               cd_d    = 1'b0;
            end else if (tick) begin
               if (rem_q <= 16'd1) begin
                  state_d = StStandby;
                  speed_d = 3'd0;
                  rem_d   = 16'd0;
                  cd_d    = 1'b0;
               end else begin
                  rem_d = rem_q - 16'd1;
               end
            end
         end

         StClean: begin
            if (tick) begin
               if (rem_q <= 16'd1) begin
                  state_d = StStandby;
                  rem_d   = 16'd0;
                  cd_d    = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  rem_d = rem_q - 16'd1;
               end
            end
         end

         default: begin
            state_d = StStandby;
            speed_d = 3'd0;
            rem_d   = 16'd0;
            cd_d    = 1'b0;
         end
      endcase
   end

   // Prescaler restarts from zero on every state change so the first tick lands CLK_HZ
   // cycles after entry.
   always_comb begin
      presc_d = '0;
      if (presc_run && (state_d == state_q)) begin
         presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StStandby;
         speed_q <= 3'd0;
         rem_q   <= 16'd0;
         cd_q    <= 1'b0;
         done_q  <= 1'b0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         speed_q <= speed_d;
         rem_q   <= rem_d;
         cd_q    <= cd_d;
         done_q  <= done_d;
         presc_q <= presc_d;
      end
   end

`ifdef HOOD_MENU_TIMEOUT_EN
   // Menu idle-seconds counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         menu_sec_q <= 16'd0;
      end else begin
         menu_sec_q <= menu_sec_d;
      end
   end
`endif

   assign mode        = state_q;
   assign speed_level = speed_q;
   assign countdown   = cd_q;
   assign remaining_s = rem_q;
   assign clean_done  = done_q;

endmodule
